// File: rtl/mem_arbiter_pkg.sv
// Shared constants and state encoding for the unified-memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int BE_W             = 4;
  localparam int CNT_W            = 4;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_age_cnt.sv
// Saturating age counter: counts fetch-wait cycles up to the programmed limit.
module mem_arb_age_cnt
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  input  logic [CNT_W-1:0] sat,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  assign full = (count == sat);

  // clr wins over inc so a grant always restarts the age from zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !full) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of one single-port memory; one transaction in flight.
// Handshake: a requester raises req with stable fields and holds them until it
// sees gnt (combinational, IDLE only); completion is flagged by a one-cycle done.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [BE_W-1:0]   dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_t            state,
  output logic [CNT_W-1:0]  wait_cnt
);

  state_t next_state;
  logic   starved;

  mem_arb_age_cnt u_age_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (if_req & ~if_gnt),
    .clr   (if_gnt),
    .sat   (CNT_W'(STARVE_LIMIT)),
    .count (wait_cnt),
    .full  (starved)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Data wins a tie unless fetch has aged out; grants are suppressed during reset.
  always_comb begin
    next_state = state;
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (reset) begin
          if (if_req && (!dm_req || starved)) begin
            if_gnt     = 1'b1;
            next_state = BUSY_IF;
          end else if (dm_req) begin
            dm_gnt     = 1'b1;
            next_state = BUSY_DM;
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (if_gnt) begin
        // fetch leaves mem_wdata at whatever the last data write left there
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_be   <= '1;
        mem_addr <= if_addr;
      end else if (dm_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_be    <= dm_be;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (state != IDLE && mem_ready) begin
        mem_req <= 1'b0;
        if (state == BUSY_IF) begin
          if_done  <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          dm_done <= 1'b1;
          if (!mem_we) begin
            dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule
